// File: rtl/rns_mod_mul_seq.sv
// rns_mod_mul_seq: multi-channel RNS modular multiply/add unit.
// Each channel reduces its 2W-bit dividend with a bit-serial restoring
// remainder engine. All channels share one FSM and bit counter.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand-set handshake (in_ready is combinational)
//   op                   0 = multiply, 1 = add (sampled at accept)
//   res_a, res_b         packed operand residues, channel i at [i*W +: W]
//   moduli               packed per-channel moduli (sampled at accept)
//   out_valid/out_ready  result handshake
//   result               packed per-channel results
//   mod_err              per-channel flag: modulus was zero
module rns_mod_mul_seq #(
  parameter int W    = 3,
  parameter int N_CH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op,
  input  logic [N_CH*W-1:0] res_a,
  input  logic [N_CH*W-1:0] res_b,
  input  logic [N_CH*W-1:0] moduli,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_CH*W-1:0] result,
  output logic [N_CH-1:0]   mod_err
);

  localparam int unsigned DW    = 2 * W;
  localparam int unsigned CNT_W = $clog2(DW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REDUCE,
    S_DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  logic [DW-1:0] d_q    [N_CH];
  logic [W-1:0]  r_q    [N_CH];
  logic [W-1:0]  m_q    [N_CH];
  logic [W:0]    t      [N_CH];
  logic [W-1:0]  r_nxt  [N_CH];
  logic [DW-1:0] d_load [N_CH];

  // Next-state decode and input-side handshake.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = !rst;
      end
      S_REDUCE: begin
        if (cnt == CNT_LAST) next_state = S_DONE;
      end
      S_DONE: begin
        in_ready = out_ready && !rst;
      end
      default: next_state = S_IDLE;
    endcase
    accept = in_valid && in_ready;
    if (accept) next_state = S_REDUCE;
    else if (state == S_DONE && out_ready) next_state = S_IDLE;
  end

  // Per-channel dividend formation and one restoring-remainder step.
  // r stays below m, so t - m always fits in W bits.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      if (op) d_load[i] = DW'(res_a[i*W +: W]) + DW'(res_b[i*W +: W]);
      else    d_load[i] = DW'(res_a[i*W +: W]) * DW'(res_b[i*W +: W]);
      t[i]     = {r_q[i], d_q[i][DW-1]};
      r_nxt[i] = (t[i] >= {1'b0, m_q[i]}) ? W'(t[i] - {1'b0, m_q[i]}) : W'(t[i]);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Datapath: capture at accept, shift-reduce in REDUCE, latch results on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      mod_err   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        d_q[i] <= '0;
        r_q[i] <= '0;
        m_q[i] <= '0;
      end
    end else begin
      out_valid <= (next_state == S_DONE);
      if (accept) begin
        cnt <= '0;
        for (int i = 0; i < N_CH; i++) begin
          d_q[i]     <= d_load[i];
          r_q[i]     <= '0;
          m_q[i]     <= moduli[i*W +: W];
          mod_err[i] <= (moduli[i*W +: W] == '0);
        end
      end else if (state == S_REDUCE) begin
        cnt <= cnt + CNT_W'(1);
        for (int i = 0; i < N_CH; i++) begin
          r_q[i] <= r_nxt[i];
          d_q[i] <= {d_q[i][DW-2:0], 1'b0};
          // A zero modulus would leave the raw dividend in r; force 0 instead.
          if (cnt == CNT_LAST) result[i*W +: W] <= mod_err[i] ? '0 : r_nxt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_rns_mod_mul_seq.sv
// Testbench for rns_mod_mul_seq: directed cases on a W=3/N_CH=3 instance,
// randomized scoreboard run on a W=4/N_CH=4 instance.
module tb_rns_mod_mul_seq;

  logic clk;
  logic rst;

  // W=3, N_CH=3 instance
  logic       iv3, ir3, op3, ov3, ordy3;
  logic [8:0] a3, b3, m3, res3;
  logic [2:0] err3;

  // W=4, N_CH=4 instance
  logic        iv4, ir4, op4, ov4, ordy4;
  logic [15:0] a4, b4, m4, res4;
  logic [3:0]  err4;

  int checks   = 0;
  int failures = 0;

  rns_mod_mul_seq #(.W(3), .N_CH(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .op(op3),
    .res_a(a3), .res_b(b3), .moduli(m3), .out_valid(ov3), .out_ready(ordy3),
    .result(res3), .mod_err(err3)
  );

  rns_mod_mul_seq #(.W(4), .N_CH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op(op4),
    .res_a(a4), .res_b(b4), .moduli(m4), .out_valid(ov4), .out_ready(ordy4),
    .result(res4), .mod_err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: per-channel (A op B) mod m on plain integers, zero modulus -> 0.
  function automatic logic [15:0] model4(input logic o, input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] m);
    logic [15:0] r;
    int unsigned av, bv, mv, v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      av = int'(a[i*4 +: 4]);
      bv = int'(b[i*4 +: 4]);
      mv = int'(m[i*4 +: 4]);
      v  = o ? av + bv : av * bv;
      r[i*4 +: 4] = (mv == 0) ? 4'd0 : 4'(v % mv);
    end
    return r;
  endfunction

  // Present one operand set to dut3 and let it be accepted on the next edge.
  task automatic issue3(input logic o, input logic [8:0] a, input logic [8:0] b, input logic [8:0] m);
    iv3 = 1'b1; op3 = o; a3 = a; b3 = b; m3 = m;
    #1;
    check("issue_in_ready", 64'(ir3), 64'd1);
    @(negedge clk);
    iv3 = 1'b0;
    op3 = 1'($urandom); a3 = 9'($urandom); b3 = 9'($urandom); m3 = 9'($urandom);
  endtask

  // Wait (bounded) for out_valid, checking latency, result and mod_err.
  task automatic collect3(input string tag, input logic [8:0] er, input logic [2:0] ee);
    int lat;
    lat = 0;
    while (!ov3 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd6);
    check({tag, "_res"}, 64'(res3), 64'(er));
    check({tag, "_err"}, 64'(err3), 64'(ee));
  endtask

  task automatic run3(input string tag, input logic o, input logic [8:0] a, input logic [8:0] b,
                      input logic [8:0] m, input logic [8:0] er, input logic [2:0] ee);
    issue3(o, a, b, m);
    collect3(tag, er, ee);
    @(negedge clk);
    check({tag, "_drained"}, 64'(ov3), 64'd0);
  endtask

  initial begin
    logic [8:0]  m357, opa, opb, held;
    logic [15:0] expq[$];
    logic [15:0] e;
    int stale, acc, cons, cyc;
    logic pend;

    m357 = {3'd3, 3'd5, 3'd7};
    opa  = {3'd2, 3'd4, 3'd6};
    opb  = {3'd2, 3'd4, 3'd5};

    rst = 1'b1;
    iv3 = 0; op3 = 0; a3 = '0; b3 = '0; m3 = '0; ordy3 = 1'b1;
    iv4 = 0; op4 = 0; a4 = '0; b4 = '0; m4 = '0; ordy4 = 1'b0;

    #12;
    check("rst_in_ready", 64'(ir3), 64'd0);
    check("rst_out_valid", 64'(ov3), 64'd0);
    check("rst_result", 64'(res3), 64'd0);
    check("rst_mod_err", 64'(err3), 64'd0);
    check("rst_in_ready4", 64'(ir4), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(ir3), 64'd1);
    @(negedge clk);

    // Multiply, add, out-of-range operands
    run3("mul", 1'b0, opa, opb, m357, {3'd1, 3'd1, 3'd2}, 3'b000);
    run3("add", 1'b1, opa, opb, m357, {3'd1, 3'd3, 3'd4}, 3'b000);
    run3("mul77", 1'b0, {3'd7, 3'd7, 3'd7}, {3'd7, 3'd7, 3'd7}, m357, {3'd1, 3'd4, 3'd0}, 3'b000);

    // Zero and unit modulus, then clearing of mod_err
    run3("zero_mod", 1'b0, {3'd5, 3'd3, 3'd3}, {3'd5, 3'd3, 3'd3}, {3'd0, 3'd1, 3'd7},
         {3'd0, 3'd0, 3'd2}, 3'b100);
    run3("clear_err", 1'b0, opa, opb, m357, {3'd1, 3'd1, 3'd2}, 3'b000);

    // Backpressure: hold the result, ignore new operands, then consume + accept together
    ordy3 = 1'b0;
    issue3(1'b0, opa, opb, m357);
    collect3("bp", {3'd1, 3'd1, 3'd2}, 3'b000);
    held = res3;
    for (int i = 0; i < 10; i++) begin
      iv3 = 1'b1; op3 = 1'($urandom); a3 = 9'($urandom); b3 = 9'($urandom); m3 = 9'($urandom);
      #1;
      check("bp_in_ready", 64'(ir3), 64'd0);
      @(negedge clk);
      check("bp_valid", 64'(ov3), 64'd1);
      check("bp_stable", 64'(res3), 64'(held));
    end
    ordy3 = 1'b1;
    issue3(1'b1, opa, opb, m357);
    check("bp_consumed", 64'(ov3), 64'd0);
    collect3("bp_next", {3'd1, 3'd3, 3'd4}, 3'b000);
    @(negedge clk);

    // Reset in the middle of a transaction
    issue3(1'b0, {3'd5, 3'd3, 3'd3}, {3'd5, 3'd3, 3'd3}, {3'd0, 3'd1, 3'd7});
    check("pre_rst_err", 64'(err3), 64'b100);
    check("pre_rst_res", 64'(res3), 64'({3'd1, 3'd3, 3'd4}));
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(ov3), 64'd0);
    check("mid_rst_result", 64'(res3), 64'd0);
    check("mid_rst_err", 64'(err3), 64'd0);
    check("mid_rst_ready", 64'(ir3), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready", 64'(ir3), 64'd1);
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov3) stale++;
    end
    check("no_stale", 64'(stale), 64'd0);
    check("no_stale_res", 64'(res3), 64'd0);

    // Randomized run on the W=4, N_CH=4 instance against the scoreboard
    acc = 0; cons = 0; cyc = 0; pend = 1'b0;
    while ((acc < 1000 || expq.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (!pend && acc < 1000 && ($urandom % 3 != 0)) begin
        pend = 1'b1;
        op4  = 1'($urandom);
        a4   = 16'($urandom);
        b4   = 16'($urandom);
        for (int i = 0; i < 4; i++) m4[i*4 +: 4] = 4'($urandom_range(15, 1));
      end
      iv4   = pend;
      ordy4 = ($urandom % 4 != 0);
      #1;
      if (ov4 && ordy4) begin
        if (expq.size() == 0) begin
          check("rnd_spurious", 64'(expq.size()), 64'd1);
        end else begin
          e = expq.pop_front();
          check("rnd_res", 64'(res4), 64'(e));
          check("rnd_err", 64'(err4), 64'd0);
          cons++;
        end
      end
      if (pend && ir4) begin
        expq.push_back(model4(op4, a4, b4, m4));
        acc++;
        pend = 1'b0;
      end
    end
    check("rnd_accepted", 64'(acc), 64'd1000);
    check("rnd_consumed", 64'(cons), 64'd1000);
    check("rnd_queue_empty", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rns_mod_mul_seq.md
# rns_mod_mul_seq

Parametrised, multi-channel residue-number-system (RNS) arithmetic unit performing per-channel modular multiply or modular add. Each channel reduces its result with a bit-serial restoring remainder engine, so any modulus, including non-power-of-two, needs no divider array. The block sits behind the binary-to-residue converter and ahead of the residue-to-binary converter. It handles all RNS channels of one operand pair in parallel with a valid/ready handshake on both sides.

## Interface
Parameters:
- W, 3, residue and modulus width per channel, in bits (W ≥ 2)
- N_CH, 3, number of RNS channels; channel i occupies bits [i*W +: W] of every packed bus

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept an operand set
- op  input  1  0 = modular multiply, 1 = modular add; sampled at accept
- res_a  input  N_CH*W  packed residues, operand A
- res_b  input  N_CH*W  packed residues, operand B
- moduli  input  N_CH*W  packed per-channel moduli; sampled at accept
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  N_CH*W  packed per-channel results
- mod_err  output  N_CH  per-channel flag: the channel's modulus was 0

## Operation
- **Accept.** Accept occurs when in_valid && in_ready.
- **Capture.** At accept, for each channel the block registers:
  - modulus m_i
  - dividend D_i, 2W bits: A_i*B_i if op=0, or A_i+B_i zero-extended if op=1
  - remainder register r_i = 0, W+1 bits
  - bit counter = 0
- **Operand range.** Operands need not be less than m_i. Results are always (A op B) mod m_i, computed on full integer values.
- **States:**
  - IDLE: in_ready=1, out_valid=0.
  - REDUCE: in_ready=0, out_valid=0. Each cycle, every channel computes t = {r_i[W-1:0], D_i[2W-1-cnt]}, then r_i = (t ≥ m_i) ? t − m_i : t. cnt increments. After the cycle with cnt = 2W−1, go to DONE.
  - DONE: out_valid=1; result_i = r_i[W-1:0]; in_ready = out_ready.
- **Transitions:**
  - IDLE → REDUCE on accept.
  - DONE → IDLE on out_ready && !in_valid.
  - DONE → REDUCE on out_ready && in_valid. The result is consumed and a new set accepted on the same edge.
  - DONE holds while out_ready=0. result and mod_err stay stable.
- **Zero modulus.** If m_i == 0, channel i returns result_i = 0 and mod_err[i] = 1 for that transaction. Other channels are unaffected.
- **Clearing mod_err.** mod_err is registered at accept and cleared at the next accept.
- **Modulus of 1.** m_i == 1 gives result_i = 0 and mod_err[i] = 0.
- **Channel timing.** All channels share one FSM and counter, and finish on the same cycle.
- **Ignored inputs.** Inputs are ignored when in_ready=0. The op, res_a, res_b and moduli inputs may change freely after accept.

## Timing
- **Reset values.** Asynchronous rst forces:
  - state IDLE
  - out_valid=0, result=0, mod_err=0
  - D, r and cnt = 0
- **in_ready during and after reset.** in_ready is 0 while rst is high, and 1 from the first cycle after deassertion.
- **Reset mid-transaction.** An in-flight transaction is discarded and no out_valid is produced for it.
- **Latency.** With accept at rising edge k, out_valid rises after edge k+2W, i.e. 6 cycles for W=3.
- **Throughput.** Without backpressure, one transaction per 2W+1 cycles is guaranteed. Back-to-back operation uses DONE→REDUCE.
- **Registered outputs.** out_valid, result and mod_err are registered. in_ready is a combinational decode of state, qualified by out_ready only in DONE.

## Test plan
1. **Multiply.** W=3, N_CH=3, moduli {ch2,ch1,ch0} = {3,5,7}, A = {2,4,6}, B = {2,4,5}, op=0. Required: result {1,1,2}, mod_err 000, out_valid exactly 6 cycles after accept.
2. **Add, out-of-range operands.** Same moduli, op=1, A = {2,4,6}, B = {2,4,5} → result {1,3,4}. Then A = {7,7,7}, B = {7,7,7}, op=0 → {1,4,0}.
3. **Zero and unit modulus.** moduli {0,1,7}, A = {5,3,3}, B = {5,3,3}, op=0. Required: result {0,0,2}, mod_err = 100. The next transaction, with a nonzero modulus, clears mod_err.
4. **Backpressure.** Hold out_ready=0 for 10 cycles after out_valid. Required: result stable, in_ready=0, new in_valid ignored. Then out_ready=1 and in_valid=1 on the same cycle: the old result is consumed, the new set is accepted, and the next out_valid follows 6 cycles later.
5. **Reset mid-transaction.** Assert rst 3 cycles after accept. Required: out_valid=0, result=0 and mod_err=0 immediately, not waiting for a clock edge. in_ready=1 on the first cycle after release, and no stale result appears.
6. **Randomised, W=4, N_CH=4.** Run 1000 transactions with random moduli 1..15, random operands and op, and random in_valid/out_ready gaps. Every result must equal the reference (A op B) mod m, with no lost or duplicated transactions.
